// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared FSM state type and default constants for the SPI trace block
package debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_NCH = 4;
  localparam int DEF_W   = 32;
  localparam int DEF_DIV = 4;
  localparam int DEF_GAP = 2;

endpackage

// File: rtl/sck_divider.sv
// rtl/sck_divider.sv - half-period counter producing sck rise/fall strobes
module sck_divider
  import debug_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          tick;

  // A strobe fires in the last cycle of each half-period; phase_q tracks the current sck level.
  assign tick     = en && (cnt_q == CNT_LAST);
  assign sck_rise = tick && !phase_q;
  assign sck_fall = tick && phase_q;

  // Counter and phase restart from zero whenever the shifter is not running.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (tick) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/debug_spi_trace.sv
// rtl/debug_spi_trace.sv - snapshot trace channels and shift them out on parallel SPI lanes
module debug_spi_trace
  import debug_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int W         = DEF_W,
  parameter int DIV       = DEF_DIV,
  parameter int GAP       = DEF_GAP,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [NCH*W-1:0] ch_data,
  input  logic [NCH-1:0]   ch_valid,
  output logic             busy,
  output logic             done,
  output logic             spi_sck,
  output logic [NCH-1:0]   spi_cs,
  output logic [NCH-1:0]   spi_mosi
);

  localparam int BW = $clog2(W) + 1;
  localparam int GW = $clog2(GAP + 1) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  // Index of the bit that goes out next on each lane.
  localparam int FB = (MSB_FIRST != 0) ? (W - 1) : 0;

  state_t          state_q;
  logic            busy_q;
  logic            done_q;
  logic            sck_q;
  logic [NCH-1:0]  cs_q;
  logic [NCH-1:0]  valid_q;
  logic [BW-1:0]   bit_q;
  logic [GW-1:0]   gap_q;

  logic            sck_rise;
  logic            sck_fall;
  logic            load;
  logic            advance;
  logic            finish;

  sck_divider #(
    .DIV (DIV)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == ST_SHIFT),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // Lane control: snapshot on an accepted capture, step on every sck fall, clear after the last bit.
  assign load    = (state_q == ST_IDLE) && capture;
  assign advance = (state_q == ST_SHIFT) && sck_fall && (bit_q != BIT_LAST);
  assign finish  = (state_q == ST_SHIFT) && sck_fall && (bit_q == BIT_LAST);

  // Frame sequencer: IDLE -> SHIFT (W sck periods) -> GAP -> IDLE with a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= '1;
      valid_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            valid_q <= ch_valid;
            cs_q    <= ~ch_valid;
            sck_q   <= 1'b0;
            bit_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            sck_q <= 1'b1;
          end else if (sck_fall) begin
            sck_q <= 1'b0;
            if (bit_q == BIT_LAST) begin
              cs_q  <= '1;
              bit_q <= '0;
              if (GAP == 0) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_GAP;
                gap_q   <= '0;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cs_q    <= '1;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;
    logic         mosi_q;

    // Next shift-register contents with the outgoing bit removed.
    always_comb begin
      sr_d = sr_q;
      if (MSB_FIRST != 0) sr_d = sr_q << 1;
      else                sr_d = sr_q >> 1;
    end

    // Lane register: mosi is forced low whenever this lane's chip select is inactive.
    always_ff @(posedge clk) begin
      if (rst) begin
        sr_q   <= '0;
        mosi_q <= 1'b0;
      end else if (load) begin
        sr_q   <= ch_data[gi*W +: W];
        mosi_q <= ch_valid[gi] & ch_data[gi*W + FB];
      end else if (advance) begin
        sr_q   <= sr_d;
        mosi_q <= valid_q[gi] & sr_d[FB];
      end else if (finish) begin
        sr_q   <= '0;
        mosi_q <= 1'b0;
      end
    end

    assign spi_mosi[gi] = mosi_q;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign spi_sck = sck_q;
  assign spi_cs  = cs_q;

endmodule

// File: tb/tb_debug_spi_trace.sv
// tb/tb_debug_spi_trace.sv - scoreboard bench for debug_spi_trace
module tb_debug_spi_trace;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int DIV = 2;
  localparam int GAP = 2;
  localparam int SHIFT_CYC = W * 2 * DIV;
  localparam int LAT = SHIFT_CYC + GAP + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;

  logic             capture = 1'b0;
  logic [NCH*W-1:0] ch_data = '0;
  logic [NCH-1:0]   ch_valid = '0;
  logic             busy, done, spi_sck;
  logic [NCH-1:0]   spi_cs, spi_mosi;

  logic             capture_b = 1'b0;
  logic [NCH*W-1:0] ch_data_b = '0;
  logic [NCH-1:0]   ch_valid_b = '0;
  logic             busy_b, done_b, sck_b;
  logic [NCH-1:0]   cs_b, mosi_b;

  debug_spi_trace #(.NCH(NCH), .W(W), .DIV(DIV), .GAP(GAP), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .capture(capture), .ch_data(ch_data), .ch_valid(ch_valid),
    .busy(busy), .done(done), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi)
  );

  debug_spi_trace #(.NCH(NCH), .W(W), .DIV(DIV), .GAP(GAP), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .capture(capture_b), .ch_data(ch_data_b), .ch_valid(ch_valid_b),
    .busy(busy_b), .done(done_b), .spi_sck(sck_b), .spi_cs(cs_b), .spi_mosi(mosi_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NCH*W-1:0] data;
    logic [NCH-1:0]   valid;
    int               cap_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb_b[$];
  exp_t e_a, e_b;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int d0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the MSB-first instance: collect bits on sck rise, compare on done.
  logic         prev_sck = 1'b0;
  int           nrise;
  logic [W-1:0] got [NCH];
  int           low_cnt [NCH];
  bit           cs_bad, mosi_bad;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (spi_sck && !prev_sck) begin
        nrise++;
        for (int ch = 0; ch < NCH; ch++)
          if (!spi_cs[ch]) got[ch] = {got[ch][W-2:0], spi_mosi[ch]};
      end
      for (int ch = 0; ch < NCH; ch++)
        if (!spi_cs[ch]) low_cnt[ch]++;
      if (sb.size() > 0 && spi_cs != 4'hF && spi_cs != ~sb[0].valid) cs_bad = 1'b1;
      if ((spi_mosi & spi_cs) != '0) mosi_bad = 1'b1;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no frame pending (cycle %0d)", cyc);
      end else begin
        e_a = sb.pop_front();
        check("done_latency", 64'(cyc + 1 - e_a.cap_cyc), 64'(LAT));
        check("busy_in_done_cycle", 64'(busy), 64'(0));
        check("sck_rise_count", 64'(nrise), 64'(W));
        check("cs_shape", 64'(cs_bad), 64'(0));
        check("mosi_zero_when_cs_high", 64'(mosi_bad), 64'(0));
        for (int ch = 0; ch < NCH; ch++) begin
          check($sformatf("ch%0d_word", ch), 64'(got[ch]),
                e_a.valid[ch] ? 64'(e_a.data[ch*W +: W]) : 64'(0));
          check($sformatf("ch%0d_cs_low_cycles", ch), 64'(low_cnt[ch]),
                e_a.valid[ch] ? 64'(SHIFT_CYC) : 64'(0));
        end
      end
    end
    if (busy === 1'b0) begin
      nrise = 0;
      cs_bad = 1'b0;
      mosi_bad = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        got[ch] = '0;
        low_cnt[ch] = 0;
      end
    end
    prev_sck = spi_sck;
  end

  // Monitor for the LSB-first instance, lane 0 only.
  logic         prev_sck_b = 1'b0;
  logic [W-1:0] got_b;
  int           nrise_b;
  logic         first_b;

  always @(negedge clk) begin
    if (busy_b === 1'b1 && sck_b && !prev_sck_b && !cs_b[0]) begin
      if (nrise_b == 0) first_b = mosi_b[0];
      got_b = {mosi_b[0], got_b[W-1:1]};
      nrise_b++;
    end
    if (done_b === 1'b1) begin
      if (sb_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done_lsb: got done=1 expected no frame pending (cycle %0d)", cyc);
      end else begin
        e_b = sb_b.pop_front();
        check("lsb_first_bit", 64'(first_b), 64'(e_b.data[0]));
        check("lsb_word", 64'(got_b), 64'(e_b.data[W-1:0]));
        check("lsb_done_latency", 64'(cyc + 1 - e_b.cap_cyc), 64'(LAT));
      end
    end
    if (busy_b === 1'b0) begin
      got_b = '0;
      nrise_b = 0;
      first_b = 1'b0;
    end
    prev_sck_b = sck_b;
  end

  // Caller is at a negedge; capture is sampled at the next posedge.
  task automatic start_frame(input logic [NCH*W-1:0] d, input logic [NCH-1:0] v, input bit expect_it);
    exp_t e;
    ch_data = d;
    ch_valid = v;
    capture = 1'b1;
    if (expect_it) begin
      e.data = d;
      e.valid = v;
      e.cap_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    capture = 1'b0;
  endtask

  task automatic wait_done(input bit lsb, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (((lsb ? done_b : done) !== 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(lsb ? "wait_done_lsb" : "wait_done", 64'(lsb ? done_b : done), 64'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    exp_t eb;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sck", 64'(spi_sck), 64'(0));
    check("rst_cs", 64'(spi_cs), 64'(4'hF));
    check("rst_mosi", 64'(spi_mosi), 64'(0));
    check("rst_cs_lsb", 64'(cs_b), 64'(4'hF));
    rst = 1'b0;

    // Single channel.
    @(negedge clk);
    start_frame({32'h0, 32'h0, 32'h0, 32'hA5A50001}, 4'b0001, 1'b1);
    wait_done(1'b0, 200);

    // All channels; inputs scrambled right after the capture edge.
    @(negedge clk);
    start_frame({32'h80000001, 32'h12345678, 32'hFFFFFFFF, 32'h00000000}, 4'b1111, 1'b1);
    ch_data = {4{32'h5A5AC3C3}};
    ch_valid = 4'b0000;
    wait_done(1'b0, 200);

    // Back-to-back frame from the done cycle, then an ignored capture mid-frame.
    @(negedge clk);
    start_frame({32'h0, 32'hCAFEF00D, 32'h0, 32'h13579BDF}, 4'b0101, 1'b1);
    wait_done(1'b0, 200);
    start_frame({32'h0F0F0F0F, 32'h0, 32'h76543210, 32'h0}, 4'b1010, 1'b1);
    repeat (9) @(negedge clk);
    d0 = done_cnt;
    ch_data = {4{32'hDEADBEEF}};
    ch_valid = 4'b1111;
    capture = 1'b1;
    @(negedge clk);
    capture = 1'b0;
    wait_done(1'b0, 200);
    repeat (150) @(negedge clk);
    check("busy_capture_single_done", 64'(done_cnt - d0), 64'(1));
    check("idle_after_ignored_capture", 64'(busy), 64'(0));

    // Reset during SHIFT.
    @(negedge clk);
    start_frame({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 4'b1111, 1'b0);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    capture = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    capture = 1'b0;
    check("abort_cs", 64'(spi_cs), 64'(4'hF));
    check("abort_sck", 64'(spi_sck), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_mosi", 64'(spi_mosi), 64'(0));
    d0 = done_cnt;
    repeat (200) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'(0));

    // Empty mask still runs full frame timing.
    @(negedge clk);
    start_frame({32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0000, 1'b1);
    wait_done(1'b0, 200);

    // LSB-first instance.
    @(negedge clk);
    ch_data_b = {32'h0, 32'h0, 32'h0, 32'h00000001};
    ch_valid_b = 4'b0001;
    capture_b = 1'b1;
    eb.data = ch_data_b;
    eb.valid = ch_valid_b;
    eb.cap_cyc = cyc + 1;
    sb_b.push_back(eb);
    @(negedge clk);
    capture_b = 1'b0;
    wait_done(1'b1, 200);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size() + sb_b.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_spi_trace.md
DEBUG_SPI_TRACE -- requirements
Module: debug_spi_trace

Interface
REQ-001 Parameter NCH, default 4: number of trace channels.
REQ-002 Parameter W, default 32: bits per channel word.
REQ-003 Parameter DIV, default 4: clk cycles per sck half-period, minimum 1.
REQ-004 Parameter GAP, default 2: idle clk cycles after cs deassert, before done; minimum 0.
REQ-005 Parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = LSB first.
REQ-006 clk  in  1  sole clock; all logic on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 capture  in  1  single-cycle request to snapshot and send one frame.
REQ-009 ch_data  in  NCH*W  channel words; channel i at bits [i*W+W-1 : i*W].
REQ-010 ch_valid  in  NCH  per-channel enable; only valid channels assert cs.
REQ-011 busy  out  1  high while a frame is shifting or in gap.
REQ-012 done  out  1  one-cycle pulse at frame completion.
REQ-013 spi_sck  out  1  shared serial clock, idle low (mode 0).
REQ-014 spi_cs  out  NCH  per-channel chip select, active-low.
REQ-015 spi_mosi  out  NCH  per-channel serial data.

Function
REQ-016 The block SHALL implement FSM states IDLE, SHIFT, GAP.
REQ-017 In IDLE, capture=1 SHALL latch ch_data and ch_valid at that edge and enter SHIFT next cycle; later input changes SHALL NOT affect the frame.
REQ-018 capture while busy=1 SHALL be ignored, with no queuing.
REQ-019 In SHIFT, spi_cs[i] SHALL be low iff latched ch_valid[i]=1; others stay high.
REQ-020 First SHIFT cycle: sck=0, mosi[i] = first bit (bit W-1 if MSB_FIRST, else bit 0).
REQ-021 sck SHALL be low DIV cycles, then high DIV cycles, per bit; mosi SHALL change only on the clk edge where sck falls (peripheral samples on sck rise).
REQ-022 After W full sck periods (W*2*DIV cycles in SHIFT), all cs SHALL go high, sck=0, and the FSM SHALL enter GAP.
REQ-023 GAP SHALL last GAP cycles (GAP=0: skip directly); then done=1 for exactly one cycle, entering IDLE.
REQ-024 busy SHALL be 1 throughout SHIFT and GAP and 0 in IDLE, including the done cycle.
REQ-025 A capture asserted in the done cycle SHALL be accepted (back-to-back frames).
REQ-026 ch_valid all-zero at capture SHALL still run full frame timing with all cs high, then pulse done.
REQ-027 Bit counter width SHALL be clog2(W)+1; divider counter width clog2(DIV)+1; no wrap before frame end.
REQ-028 mosi[i] for channels with cs high SHALL be driven 0.

Reset
REQ-029 On rst=1 at a clk edge, next state SHALL be IDLE with busy=0, done=0, sck=0, spi_cs all 1, spi_mosi all 0, counters 0.
REQ-030 rst mid-frame SHALL abort immediately, with no done pulse and no partial-frame completion.
REQ-031 rst SHALL dominate capture in the same cycle.

Structure
REQ-032 A shared package debug_pkg SHALL hold the FSM state typedef and default constants (NCH, W, DIV, GAP).
REQ-033 One sub-module, sck_divider (counter producing sck-rise/sck-fall strobes from DIV), SHALL be instantiated; per-channel shift registers SHALL be a generate loop inside debug_spi_trace.

Verification (NCH=4, W=32, DIV=2, GAP=2, MSB_FIRST=1)
REQ-034 The bench SHALL cover single-channel operation: capture with ch0=0xA5A50001 and valid=0001 -> cs[0] low 128 cycles, cs[3:1] high; sampling mosi[0] on sck rise gives 0xA5A50001; done exactly 131 cycles after the capture edge.
REQ-035 The bench SHALL cover all-channel operation: ch0..3 = 0x00000000, 0xFFFFFFFF, 0x12345678, 0x80000001 with valid=1111 -> each mosi reproduces its word, all cs share identical edges, and ch_data changes after capture have no effect.
REQ-036 The bench SHALL cover back-to-back frames and capture while busy: capture in the done cycle starts a frame next cycle; capture 10 cycles into SHIFT is ignored and yields exactly one done.
REQ-037 The bench SHALL cover reset mid-frame: rst at cycle 40 of SHIFT -> next cycle cs=1111, sck=0, busy=0; no done for 200 cycles.
REQ-038 The bench SHALL cover the empty mask and LSB_FIRST case: valid=0000 -> no cs toggles and done at 131 cycles; with MSB_FIRST=0 and ch0=0x00000001, the first sampled bit is 1.
